baud_gen_frac: RTL
==================

# baud_gen_frac

Parametrised fractional baud-rate generator for the UART. It produces an oversample tick whose average period is div_int + div_frac/2^FRAC_W clock cycles, so standard baud rates hit within 1/2^FRAC_W cycle of error at any clock frequency. From that tick it derives a mid-bit sample tick and a bit tick. A resync input re-phases all three ticks to a detected RX start edge. It feeds both the TX shifter (bit_tick) and the RX sampler (mid_tick, os_tick).

## Interface
- CNT_W, 16: width of the integer divisor.
- FRAC_W, 4: width of the fractional divisor. Fractional resolution is 1/2^FRAC_W cycle.
- OSR, 16: oversample ticks per bit. Legal range is 4..64, even values only.
- OSR_W, $clog2(OSR): width of os_phase.

- clk  in  1  system clock; one clock domain only
- arst_n  in  1  reset, synchronous, active-low
- en  in  1  generator enable
- resync  in  1  restart the phase; single-cycle pulse, or held
- div_int  in  CNT_W  integer oversample period, in clk cycles
- div_frac  in  FRAC_W  fractional part of the oversample period
- os_tick  out  1  oversample tick, one cycle wide
- mid_tick  out  1  mid-bit tick, one cycle wide; always coincident with an os_tick
- bit_tick  out  1  end-of-bit tick, one cycle wide; always coincident with an os_tick
- os_phase  out  OSR_W  os_tick count within the current bit, 0..OSR-1
- cfg_err  out  1  high when div_int < 2

## Operation
- State:
  - cycle counter cnt, CNT_W+1 bits
  - current period P, CNT_W+1 bits
  - fractional accumulator acc, FRAC_W bits
  - oversample counter os_cnt, OSR_W bits
- Effective integer divisor:
  - di = max(div_int, 2).
  - cfg_err <= (div_int < 2), registered every cycle.
- Priority order at each rising edge:
  1. Reset (arst_n=0): clear all state and all outputs.
  2. en=0: clear cnt, acc and os_cnt. Set P <= di. Drive all ticks 0.
  3. resync=1: same clearing as en=0, and P <= di. No tick in the following cycle.
  4. cnt == P-1 (period end):
     - cnt <= 0, os_tick <= 1.
     - Compute sum = acc + div_frac (FRAC_W+1 bits).
     - acc <= sum[FRAC_W-1:0], P <= di + sum[FRAC_W].
  5. Otherwise: cnt <= cnt + 1, all ticks <= 0.
- Oversample counter, on each period end:
  - mid_tick <= (os_cnt == OSR/2-1).
  - bit_tick <= (os_cnt == OSR-1).
  - os_cnt <= (os_cnt == OSR-1) ? 0 : os_cnt + 1.
- os_phase = os_cnt.
- div_int and div_frac are sampled only at period end and on en=0 or resync. A change mid-period takes effect at the next boundary; the current period is never shortened.
- Over any 2^FRAC_W consecutive periods after the first, exactly div_frac periods are di+1 long and the rest are di.

## Timing
- Reset values:
  - os_tick, mid_tick, bit_tick, cfg_err: 0
  - os_phase: 0
- Latency:
  - The first os_tick is high in the cycle after the P-th edge with en=1 (counting that edge as edge 1).
  - P for that first period is di, with no fractional extension.
  - The same rule applies after resync: the first os_tick follows the di-th edge after the resync edge.
- Ticks are registered and glitch-free. They are never wider than one cycle, since P >= 2 guarantees a gap.
- Tick spacing:
  - bit_tick follows every OSR os_ticks.
  - The first mid_tick comes with the (OSR/2)-th os_tick after en or resync.
  - The first bit_tick comes with the OSR-th os_tick.
- resync in the same cycle as a period end: resync wins, with no tick and the phase cleared.
- Held resync or held en=0: the block stays cleared and no ticks are produced.
- Dropping en mid-bit: ticks are forced low from the next cycle. Re-enabling starts a fresh bit at os_phase 0.
- div_int = 2^CNT_W-1 with a fractional carry: P = 2^CNT_W. This fits the CNT_W+1-bit counter, so there is no wrap.

## Test plan
- Reset and enable:
  - Stimulus: hold arst_n=0 for 3 cycles with en=1, then release.
  - Required: all outputs 0 during reset. With div_int=4, div_frac=0, OSR=16, the first os_tick comes 4 cycles after release, then one every 4 cycles. bit_tick occurs every 64 cycles, and mid_tick 32 cycles after release.
- Fractional divisor:
  - Stimulus: div_int=10, div_frac=8, FRAC_W=4.
  - Required: os_tick periods 10, 10, 11, 10, 11, and so on. Over 32 periods after the first, the total is exactly 336 cycles.
- Resync:
  - Stimulus: pulse resync at os_phase=9, in the middle of a period.
  - Required: no tick on the next cycle. os_phase becomes 0, the next os_tick comes di cycles later, and mid_tick arrives with the 8th os_tick after resync.
- Clamp:
  - Stimulus: div_int=0, then div_int=1.
  - Required: cfg_err=1, and os_tick occurs every 2 cycles. Setting div_int=5 makes cfg_err fall one cycle later.
- Divisor change mid-period:
  - Stimulus: switch div_int 8→3 at cnt=2.
  - Required: the current period still lasts 8 cycles, and the following periods last 3 cycles.
- en drop and simultaneity:
  - Stimulus: deassert en at os_phase=5. Separately, assert resync on a period-end cycle.
  - Required: with en dropped, ticks stop immediately and, after re-enable, the phase restarts at 0. With resync on a period end, no os_tick is emitted and the phase clears.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: os_tick every div_int + div_frac/2^FRAC_W cycles on average, plus mid-bit and end-of-bit ticks.
// Latency: first os_tick is high the cycle after the di-th enabled edge following reset, en rise or resync; all outputs registered.
// Backpressure: none; free-running while en=1, held cleared while en=0 or resync=1.
//
// Ports:
//   clk, arst_n       single clock; synchronous active-low reset
//   en, resync        generator enable; phase restart (pulse or held)
//   div_int, div_frac integer and fractional oversample period (clk cycles)
//   os_tick           oversample tick; mid_tick / bit_tick coincide with an os_tick
//   os_phase          os_tick count within the current bit, 0..OSR-1
//   cfg_err           registered flag, high when div_int < 2 (period clamped to 2)
module baud_gen_frac #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OSR    = 16,
    parameter int OSR_W  = $clog2(OSR)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic              resync,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic [OSR_W-1:0]  os_phase,
    output logic              cfg_err
);

    // One extra bit so that a period of 2^CNT_W (max div_int plus carry) fits.
    localparam int PW = CNT_W + 1;

    localparam logic [OSR_W-1:0] OS_LAST = OSR_W'(OSR - 1);
    localparam logic [OSR_W-1:0] OS_MID  = OSR_W'(OSR / 2 - 1);

    logic [PW-1:0]     cnt_q,      cnt_d;
    logic [PW-1:0]     per_q,      per_d;
    logic [FRAC_W-1:0] acc_q,      acc_d;
    logic [OSR_W-1:0]  os_cnt_q,   os_cnt_d;
    logic              os_tick_q,  os_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              cfg_err_q,  cfg_err_d;

    logic              div_small;
    logic [CNT_W-1:0]  di;
    logic [PW-1:0]     di_ext;
    logic [PW-1:0]     per_eff;
    logic              period_end;
    logic [FRAC_W:0]   sum;

    // Periods below 2 would make ticks wider than one cycle, so clamp.
    assign div_small = (div_int < CNT_W'(2));
    assign di        = div_small ? CNT_W'(2) : div_int;
    assign di_ext    = {1'b0, di};

    // Reset clears the period register to 0; until the first edge has
    // latched a real period, use the live clamped divisor so the first
    // period out of reset is di long, same as after en or resync.
    assign per_eff    = (per_q == '0) ? di_ext : per_q;
    assign period_end = (cnt_q == per_eff - PW'(1));

    // Fractional carry stretches the next period by one cycle.
    assign sum = {1'b0, acc_q} + {1'b0, div_frac};

    always_comb begin
        cnt_d      = cnt_q;
        per_d      = per_q;
        acc_d      = acc_q;
        os_cnt_d   = os_cnt_q;
        os_tick_d  = 1'b0;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;
        cfg_err_d  = div_small;

        if (!en || resync) begin
            // Restart: the next period is exactly di, accumulator empty,
            // and a fresh bit begins at phase 0.
            cnt_d    = '0;
            acc_d    = '0;
            os_cnt_d = '0;
            per_d    = di_ext;
        end else if (period_end) begin
            cnt_d      = '0;
            os_tick_d  = 1'b1;
            mid_tick_d = (os_cnt_q == OS_MID);
            bit_tick_d = (os_cnt_q == OS_LAST);
            os_cnt_d   = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSR_W'(1);
            acc_d      = sum[FRAC_W-1:0];
            // Divisor is sampled here only, so a mid-period change never
            // shortens the period already in progress.
            per_d      = di_ext + PW'(sum[FRAC_W]);
        end else begin
            cnt_d = cnt_q + PW'(1);
            per_d = per_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cnt_q      <= '0;
            per_q      <= '0;
            acc_q      <= '0;
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign mid_tick = mid_tick_q;
    assign bit_tick = bit_tick_q;
    assign os_phase = os_cnt_q;
    assign cfg_err  = cfg_err_q;

endmodule
